// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, idle fill byte, responder state.
// Used by both the SPI responder and the SPI master.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_slave_os_sync.sv
// N-flop synchroniser for one async pin, plus one extra flop
// that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_os.sv
// SPI responder oversampled by the system clock, all four modes,
// MSB first, with a 1-entry tx holding register.
import spi_pkg::*;

module spi_slave_os #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       underrun
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk_pin),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // CS resets to deasserted so a reset never fakes a frame start
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs_pin),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
  end

  assign mosi = mosi_sync[SYNC_STAGES-1];

  state_t state_q, state_d;

  logic       sclk_edge, lead, trail;
  logic       sample, shift, last, load;
  logic       accept;
  logic       hold_full;
  logic [7:0] hold;
  logic [7:0] next_byte;
  logic [7:0] tx_sh;
  logic [6:0] rx_sh;
  logic [2:0] cnt;

  assign sclk_edge = sclk_rise | sclk_fall;
  assign lead      = sclk_edge & (sclk_lvl != CPOL);
  assign trail     = sclk_edge & (sclk_lvl == CPOL);

  assign sample = (state_q == ACTIVE) & ~cs_rise
                & (CPHA ? trail : lead);
  assign shift  = (state_q == ACTIVE) & ~cs_rise
                & (CPHA ? lead : trail);
  assign last   = sample & (cnt == 3'd7);
  assign load   = (state_q == LOAD) | last;

  assign accept    = tx_valid & ~hold_full;
  assign tx_ready  = ~hold_full;
  assign next_byte = hold_full ? hold : IDLE_BYTE;
  assign busy      = ~cs_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    miso_oe = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        miso_oe = 1'b1;
        state_d = cs_rise ? IDLE : ACTIVE;
      end
      ACTIVE: begin
        miso_oe = 1'b1;
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cnt       <= '0;
      miso_pin  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      underrun  <= load & ~hold_full;
      hold_full <= (hold_full & ~load) | accept;
      if (accept) hold <= tx_data;

      case (state_q)
        IDLE: begin
          cnt      <= '0;
          miso_pin <= 1'b1;
        end
        // CPHA=0 must present the MSB before the first edge
        LOAD: begin
          if (CPHA) begin
            tx_sh <= next_byte;
          end else begin
            tx_sh    <= {next_byte[6:0], 1'b0};
            miso_pin <= next_byte[7];
          end
        end
        ACTIVE: begin
          if (sample) begin
            rx_sh <= {rx_sh[5:0], mosi};
            cnt   <= cnt + 3'd1;
          end
          if (last) begin
            rx_data  <= {rx_sh, mosi};
            rx_valid <= 1'b1;
            tx_sh    <= next_byte;
          end
          if (shift) begin
            miso_pin <= tx_sh[7];
            tx_sh    <= {tx_sh[6:0], 1'b0};
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_os.sv
// Bench for spi_slave_os: bus-level SPI master driving the pins,
// checked against a byte-level model of the holding register.
import spi_pkg::*;

module tb_spi_slave_os;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_pin, cs_pin, mosi_pin;
  logic       miso_pin, miso_oe;
  logic       CPOL, CPHA;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, underrun;

  always #5 clk = ~clk;

  spi_slave_os dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin),
    .miso_oe  (miso_oe),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .underrun (underrun)
  );

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (underrun) ur_cnt++;
  end

  // byte-level model: queued tx bytes, expected loads and counts
  logic [7:0] hold_m[$];
  logic [7:0] cur_m;
  int exp_rx = 0;
  int exp_ur = 0;

  task automatic model_load();
    if (hold_m.size() > 0) begin
      cur_m = hold_m.pop_front();
    end else begin
      cur_m = IDLE_BYTE_DEF;
      exp_ur++;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    CPOL     = m[1];
    CPHA     = m[0];
    sclk_pin = m[1];
    wclk(4);
  endtask

  task automatic push(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 200) begin
      wclk(1);
      t++;
    end
    check("push_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    wclk(1);
    tx_valid = 1'b0;
    hold_m.push_back(b);
  endtask

  task automatic frame_begin();
    cs_pin = 1'b0;
    model_load();
    wclk(H);
  endtask

  task automatic frame_end();
    wclk(H);
    cs_pin = 1'b1;
    wclk(8);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!CPHA) begin
        mosi_pin = mo[7-i];
        wclk(H);
        sclk_pin = ~CPOL;
        mi = {mi[6:0], miso_pin};
        wclk(H);
        sclk_pin = CPOL;
      end else begin
        sclk_pin = ~CPOL;
        mosi_pin = mo[7-i];
        wclk(H);
        sclk_pin = CPOL;
        mi = {mi[6:0], miso_pin};
        wclk(H);
      end
    end
  endtask

  task automatic byte_xfer(input logic [7:0] mo, input string tag);
    logic [7:0] mi;
    xfer(mo, 8, mi);
    check({tag, "_miso"}, {24'd0, mi}, {24'd0, cur_m});
    exp_rx++;
    check({tag, "_rxcnt"}, rx_cnt, exp_rx);
    check({tag, "_rxdata"}, {24'd0, rx_data}, {24'd0, mo});
    model_load();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},  {31'd0, miso_pin}, 32'd1);
    check({tag, "_oe"},    {31'd0, miso_oe},  32'd0);
    check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_rx"},    {24'd0, rx_data},  32'd0);
    check({tag, "_rxv"},   {31'd0, rx_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_ur"},    {31'd0, underrun}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] r;
    int n;
    rst = 1'b1;
    cs_pin = 1'b1;
    sclk_pin = 1'b0;
    mosi_pin = 1'b0;
    CPOL = 1'b0;
    CPHA = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    wclk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wclk(4);

    // mode 0 single byte
    push(8'hC3);
    frame_begin();
    check("m0_busy", {31'd0, busy}, 32'd1);
    check("m0_oe", {31'd0, miso_oe}, 32'd1);
    check("m0_ready_after_load", {31'd0, tx_ready}, 32'd1);
    check("m0_msb_early", {31'd0, miso_pin}, {31'd0, cur_m[7]});
    byte_xfer(8'h5A, "m0");
    frame_end();
    check("m0_oe_off", {31'd0, miso_oe}, 32'd0);
    check("m0_busy_off", {31'd0, busy}, 32'd0);
    check("m0_ur", ur_cnt, exp_ur);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      push(8'hA5);
      frame_begin();
      byte_xfer(8'h3C, "mode");
      frame_end();
      check("mode_ur", ur_cnt, exp_ur);
    end

    // 3-byte burst with just-in-time queueing
    set_mode(MODE0);
    push(8'h11);
    frame_begin();
    push(8'h22);
    byte_xfer(8'h01, "burst1");
    push(8'h33);
    byte_xfer(8'h02, "burst2");
    check("burst_no_ur", ur_cnt, exp_ur);
    byte_xfer(8'h03, "burst3");
    frame_end();
    n = rx_log.size();
    check("burst_log0", {24'd0, rx_log[n-3]}, 32'h01);
    check("burst_log1", {24'd0, rx_log[n-2]}, 32'h02);
    check("burst_log2", {24'd0, rx_log[n-1]}, 32'h03);
    check("burst_ur", ur_cnt, exp_ur);

    // underrun: nothing queued
    frame_begin();
    check("ur_at_load", ur_cnt, exp_ur);
    byte_xfer(8'h80, "ur");
    frame_end();
    check("ur_total", ur_cnt, exp_ur);

    // CS abort after 5 clocks
    push(8'h96);
    frame_begin();
    xfer(8'hE7, 5, mi);
    cs_pin = 1'b1;
    wclk(6);
    check("abort_oe", {31'd0, miso_oe}, 32'd0);
    check("abort_rxcnt", rx_cnt, exp_rx);
    push(8'hC3);
    frame_begin();
    byte_xfer(8'h5A, "after_abort");
    frame_end();

    // async reset mid-byte
    push(8'hC3);
    frame_begin();
    xfer(8'h5A, 3, mi);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    hold_m.delete();
    cs_pin = 1'b1;
    sclk_pin = CPOL;
    wclk(4);
    rst = 1'b0;
    wclk(4);
    check("midrst_rxcnt", rx_cnt, exp_rx);
    push(8'hC3);
    frame_begin();
    byte_xfer(8'h5A, "after_rst");
    frame_end();
    check("after_rst_ur", ur_cnt, exp_ur);

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      set_mode(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      frame_begin();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        if (k > 0 && $urandom_range(0, 1) == 1) push(8'($urandom));
        r = 8'($urandom);
        byte_xfer(r, "rand");
      end
      frame_end();
      check("rand_ur", ur_cnt, exp_ur);
      check("rand_oe", {31'd0, miso_oe}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
